// File: rtl/mkio_pkg.sv
// rtl/mkio_pkg.sv - shared constants and types for the MKIO receive writer
// Command-word field positions, FSM encodings, error causes and reserved addresses.
package mkio_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RECV = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   typedef enum logic [1:0] {
      ERR_NONE   = 2'd0,
      ERR_PARITY = 2'd1,
      ERR_SYNC   = 2'd2,
      ERR_GAP    = 2'd3
   } err_code_t;

   localparam int CMD_RTA_LSB = 11;
   localparam int CMD_TR_BIT  = 10;
   localparam int CMD_SA_LSB  = 5;
   localparam int CMD_WC_LSB  = 0;

   localparam logic [4:0] BCAST_ADDR = 5'd31;
   localparam logic [4:0] MODE_SA_LO = 5'd0;
   localparam logic [4:0] MODE_SA_HI = 5'd31;

   // A word-count field of zero encodes a full 32-word message.
   function automatic logic [5:0] wc_to_count(input logic [4:0] wc);
      return (wc == 5'd0) ? 6'd32 : {1'b0, wc};
   endfunction

endpackage

// File: rtl/mkio_rx_writer_if.sv
// rtl/mkio_rx_writer_if.sv - decoder word stream and buffer-memory write port
// The writer sits on the slave side; the decoder/memory environment on the master side.
interface mkio_rx_writer_if #(
   parameter int DATA_WIDTH = 16,
   parameter int ADDR_WIDTH = 5
);
   logic [15:0]           rx_word;
   logic                  rx_valid;
   logic                  rx_cmd_sync;
   logic                  rx_par_err;
   logic [DATA_WIDTH-1:0] mem_data;
   logic [ADDR_WIDTH-1:0] mem_wraddress;
   logic                  mem_wren;

   modport master (
      output rx_word, rx_valid, rx_cmd_sync, rx_par_err,
      input  mem_data, mem_wraddress, mem_wren
   );

   modport slave (
      input  rx_word, rx_valid, rx_cmd_sync, rx_par_err,
      output mem_data, mem_wraddress, mem_wren
   );
endinterface

// File: rtl/mkio_gap_timer.sv
// rtl/mkio_gap_timer.sv - inter-word gap watchdog for the receive writer
// Loads to GAP_TIMEOUT, counts down on idle cycles, flags expiry at zero.
module mkio_gap_timer #(
   parameter int GAP_TIMEOUT = 1400
) (
   input  logic clk,
   input  logic reset_n,
   input  logic i_load,
   input  logic i_dec,
   output logic o_expired
);
   localparam int W = $clog2(GAP_TIMEOUT + 1);

   logic [W-1:0] r_cnt;

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_cnt <= '0;
      end else if (i_load) begin
         r_cnt <= W'(GAP_TIMEOUT);
      end else if (i_dec && (r_cnt != '0)) begin
         r_cnt <= r_cnt - W'(1);
      end
   end

   assign o_expired = (r_cnt == '0);

endmodule

// File: rtl/mkio_rx_writer.sv
// rtl/mkio_rx_writer.sv - MKIO RT receive writer: command filter and buffer writer
// Optional broadcast (RTA 31) acceptance is built when MKIO_BCAST_EN is defined.
module mkio_rx_writer
   import mkio_pkg::*;
#(
   parameter int DATA_WIDTH  = 16,
   parameter int ADDR_WIDTH  = 5,
   parameter int GAP_TIMEOUT = 1400
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic [4:0]       rt_addr,
   mkio_rx_writer_if.slave  bus,
   output logic             busy,
   output logic [4:0]       msg_subaddr,
   output logic [5:0]       msg_count,
   output logic             msg_bcast,
   output logic             msg_done,
   output logic             tx_req,
   output logic             mode_req,
   output logic             msg_err,
   output logic [1:0]       err_code
);

   logic [1:0]            r_state;
   logic [4:0]            r_index;
   logic [DATA_WIDTH-1:0] r_mem_data;
   logic [ADDR_WIDTH-1:0] r_mem_wraddress;
   logic                  r_mem_wren;
   logic [4:0]            r_msg_subaddr;
   logic [5:0]            r_msg_count;
   logic                  r_msg_done;
   logic                  r_tx_req;
   logic                  r_mode_req;
   logic                  r_msg_err;
   err_code_t             r_err_code;

   logic [4:0] w_rta;
   logic [4:0] w_sa;
   logic [4:0] w_wc;
   logic       w_tr;
   logic       w_own;
   logic       w_bcast;
   logic       w_cmd_ok;
   logic       w_is_mode;
   logic       w_mode_acc;
   logic       w_tx_acc;
   logic       w_rx_acc;
   logic       w_latch;
   logic       w_cmd_strobe;
   logic       w_data_strobe;
   logic       w_clean_data;
   logic       w_last;
   logic       w_timer_load;
   logic       w_timer_dec;
   logic       w_timer_expired;

   assign w_rta = bus.rx_word[CMD_RTA_LSB +: 5];
   assign w_tr  = bus.rx_word[CMD_TR_BIT];
   assign w_sa  = bus.rx_word[CMD_SA_LSB +: 5];
   assign w_wc  = bus.rx_word[CMD_WC_LSB +: 5];

   // An own address of 31 would alias broadcast, so it never matches here.
   assign w_own = (w_rta == rt_addr) && (rt_addr != BCAST_ADDR);

`ifdef MKIO_BCAST_EN
   logic r_msg_bcast;

   assign w_bcast = (w_rta == BCAST_ADDR);

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_msg_bcast <= 1'b0;
      end else if (w_latch) begin
         r_msg_bcast <= w_bcast;
      end
   end

   assign msg_bcast = r_msg_bcast;
`else
   assign w_bcast   = 1'b0;
   assign msg_bcast = 1'b0;
`endif

   assign w_cmd_strobe  = bus.rx_valid & bus.rx_cmd_sync;
   assign w_data_strobe = bus.rx_valid & ~bus.rx_cmd_sync;
   assign w_cmd_ok      = w_cmd_strobe & ~bus.rx_par_err & (w_own | w_bcast);
   assign w_is_mode     = (w_sa == MODE_SA_LO) || (w_sa == MODE_SA_HI);
   assign w_mode_acc    = w_cmd_ok & w_is_mode;
   // Broadcast transmit has no single responder and is dropped.
   assign w_tx_acc      = w_cmd_ok & ~w_is_mode & w_tr & w_own;
   assign w_rx_acc      = w_cmd_ok & ~w_is_mode & ~w_tr;
   assign w_latch       = w_mode_acc | w_tx_acc | w_rx_acc;

   assign w_clean_data  = w_data_strobe & ~bus.rx_par_err & (r_state == ST_RECV);
   assign w_last        = ({1'b0, r_index} == (r_msg_count - 6'd1));
   assign w_timer_load  = w_rx_acc | w_clean_data;
   assign w_timer_dec   = (r_state == ST_RECV) & ~bus.rx_valid;

   mkio_gap_timer #(
      .GAP_TIMEOUT (GAP_TIMEOUT)
   ) u_gap_timer (
      .clk       (clk),
      .reset_n   (reset_n),
      .i_load    (w_timer_load),
      .i_dec     (w_timer_dec),
      .o_expired (w_timer_expired)
   );

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         r_state         <= ST_IDLE;
         r_index         <= '0;
         r_mem_data      <= '0;
         r_mem_wraddress <= '0;
         r_mem_wren      <= 1'b0;
         r_msg_subaddr   <= '0;
         r_msg_count     <= '0;
         r_msg_done      <= 1'b0;
         r_tx_req        <= 1'b0;
         r_mode_req      <= 1'b0;
         r_msg_err       <= 1'b0;
         r_err_code      <= ERR_NONE;
      end else begin
         r_mem_wren <= 1'b0;
         r_msg_done <= 1'b0;
         r_msg_err  <= 1'b0;
         r_tx_req   <= w_tx_acc;
         r_mode_req <= w_mode_acc;

         if (w_latch) begin
            r_msg_subaddr <= w_sa;
            r_msg_count   <= wc_to_count(w_wc);
         end

         case (r_state)
            ST_RECV: begin
               // A command mid-message aborts it and is itself evaluated as a new command.
               if (w_cmd_strobe) begin
                  r_msg_err  <= 1'b1;
                  r_err_code <= ERR_SYNC;
                  r_index    <= '0;
                  r_state    <= w_rx_acc ? ST_RECV : ST_IDLE;
               end else if (w_data_strobe && bus.rx_par_err) begin
                  r_msg_err  <= 1'b1;
                  r_err_code <= ERR_PARITY;
                  r_state    <= ST_IDLE;
               end else if (w_clean_data) begin
                  r_mem_wren      <= 1'b1;
                  r_mem_data      <= DATA_WIDTH'(bus.rx_word);
                  r_mem_wraddress <= ADDR_WIDTH'(r_index);
                  r_index         <= r_index + 5'd1;
                  if (w_last) begin
                     r_state <= ST_DONE;
                  end
               end else if (w_timer_expired) begin
                  r_msg_err  <= 1'b1;
                  r_err_code <= ERR_GAP;
                  r_state    <= ST_IDLE;
               end
            end
            ST_DONE: begin
               r_msg_done <= 1'b1;
               r_index    <= '0;
               r_state    <= w_rx_acc ? ST_RECV : ST_IDLE;
            end
            default: begin
               if (w_rx_acc) begin
                  r_index <= '0;
                  r_state <= ST_RECV;
               end
            end
         endcase
      end
   end

   assign bus.mem_data      = r_mem_data;
   assign bus.mem_wraddress = r_mem_wraddress;
   assign bus.mem_wren      = r_mem_wren;
   assign busy              = (r_state != ST_IDLE);
   assign msg_subaddr       = r_msg_subaddr;
   assign msg_count         = r_msg_count;
   assign msg_done          = r_msg_done;
   assign tx_req            = r_tx_req;
   assign mode_req          = r_mode_req;
   assign msg_err           = r_msg_err;
   assign err_code          = r_err_code;

endmodule

// File: tb/tb_mkio_rx_writer.sv
// tb/tb_mkio_rx_writer.sv - self-checking bench for mkio_rx_writer
// Table of command scenarios plus hand sequences for timing, gap boundary, sync abort and reset.
module tb_mkio_rx_writer;

   localparam int DW  = 16;
   localparam int AW  = 5;
   localparam int GAP = 16;

   logic       clk = 1'b0;
   logic       reset_n;
   logic [4:0] rt_addr;
   logic       busy;
   logic [4:0] msg_subaddr;
   logic [5:0] msg_count;
   logic       msg_bcast;
   logic       msg_done;
   logic       tx_req;
   logic       mode_req;
   logic       msg_err;
   logic [1:0] err_code;

   mkio_rx_writer_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

   mkio_rx_writer #(
      .DATA_WIDTH  (DW),
      .ADDR_WIDTH  (AW),
      .GAP_TIMEOUT (GAP)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .rt_addr     (rt_addr),
      .bus         (bus),
      .busy        (busy),
      .msg_subaddr (msg_subaddr),
      .msg_count   (msg_count),
      .msg_bcast   (msg_bcast),
      .msg_done    (msg_done),
      .tx_req      (tx_req),
      .mode_req    (mode_req),
      .msg_err     (msg_err),
      .err_code    (err_code)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [15:0] cmd;
      logic        cmd_par;
      int          ndata;
      int          bad_idx;
      int          exp_wr;
      int          exp_done;
      int          exp_tx;
      int          exp_mode;
      int          exp_err;
      logic [1:0]  exp_code;
      logic [4:0]  exp_sa;
      logic [5:0]  exp_cnt;
      logic        exp_bc;
   } vec_t;

   vec_t               vecs[$];
   logic [AW+DW-1:0]   exp_q[$];
   logic [AW+DW-1:0]   obs_q[$];
   int                 rd_obs = 0;
   int                 n_done = 0, n_tx = 0, n_mode = 0, n_err = 0;
   int                 total = 0, bad = 0;

   always @(negedge clk) begin
      if (bus.mem_wren === 1'b1) obs_q.push_back({bus.mem_wraddress, bus.mem_data});
      if (msg_done === 1'b1) n_done++;
      if (tx_req === 1'b1)   n_tx++;
      if (mode_req === 1'b1) n_mode++;
      if (msg_err === 1'b1)  n_err++;
   end

   function automatic vec_t mk(string nm, logic [15:0] c, logic cp, int nd, int bi, int ew,
                               int ed, int et, int em, int ee, logic [1:0] ec,
                               logic [4:0] es, logic [5:0] en, logic eb);
      vec_t v;
      v.name = nm; v.cmd = c; v.cmd_par = cp; v.ndata = nd; v.bad_idx = bi; v.exp_wr = ew;
      v.exp_done = ed; v.exp_tx = et; v.exp_mode = em; v.exp_err = ee; v.exp_code = ec;
      v.exp_sa = es; v.exp_cnt = en; v.exp_bc = eb;
      return v;
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", nm, act, exp);
      end
   endtask

   task automatic strobe(input logic [15:0] w, input logic c, input logic p);
      bus.rx_word     = w;
      bus.rx_cmd_sync = c;
      bus.rx_par_err  = p;
      bus.rx_valid    = 1'b1;
      @(posedge clk);
      #1;
      bus.rx_valid    = 1'b0;
      bus.rx_cmd_sync = 1'b0;
      bus.rx_par_err  = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic data(input int idx, input logic push);
      logic [15:0] d;
      d = 16'($urandom);
      if (push) exp_q.push_back({AW'(idx), d});
      strobe(d, 1'b0, 1'b0);
   endtask

   task automatic drain(input string nm);
      int n_new;
      n_new = obs_q.size() - rd_obs;
      check({nm, ".wr_count"}, 64'(n_new), 64'(exp_q.size()));
      for (int i = 0; i < exp_q.size() && i < n_new; i++)
         check({nm, ".wr"}, 64'(obs_q[rd_obs + i]), 64'(exp_q[i]));
      rd_obs = obs_q.size();
      exp_q.delete();
   endtask

   function automatic logic [63:0] all_outs();
      return 64'({busy, msg_subaddr, msg_count, msg_bcast, msg_done, tx_req, mode_req,
                  msg_err, err_code, bus.mem_wren, bus.mem_data, bus.mem_wraddress});
   endfunction

   initial begin
      int b_done, b_tx, b_mode, b_err;
      vec_t v;

      bus.rx_word = '0; bus.rx_valid = 1'b0; bus.rx_cmd_sync = 1'b0; bus.rx_par_err = 1'b0;
      reset_n = 1'b0;
      rt_addr = 5'd1;

      vecs.push_back(mk("rx3",      16'h0843, 0,  3, -1,  3, 1, 0, 0, 0, 2'd0, 5'd2,  6'd3,  0));
      vecs.push_back(mk("rx32",     16'h0840, 0, 32, -1, 32, 1, 0, 0, 0, 2'd0, 5'd2,  6'd32, 0));
      vecs.push_back(mk("parity",   16'h0843, 0,  2,  1,  1, 0, 0, 0, 1, 2'd1, 5'd2,  6'd3,  0));
      vecs.push_back(mk("gap",      16'h0843, 0,  1, -1,  1, 0, 0, 0, 1, 2'd3, 5'd2,  6'd3,  0));
      vecs.push_back(mk("other_rt", 16'h1043, 0,  1, -1,  0, 0, 0, 0, 0, 2'd3, 5'd2,  6'd3,  0));
      vecs.push_back(mk("tx",       16'h0C22, 0,  0, -1,  0, 0, 1, 0, 0, 2'd3, 5'd1,  6'd2,  0));
      vecs.push_back(mk("mode0",    16'h0802, 0,  0, -1,  0, 0, 0, 1, 0, 2'd3, 5'd0,  6'd2,  0));
      vecs.push_back(mk("mode31",   16'h0BE1, 0,  0, -1,  0, 0, 0, 1, 0, 2'd3, 5'd31, 6'd1,  0));
      vecs.push_back(mk("cmd_par",  16'h0843, 1,  3, -1,  0, 0, 0, 0, 0, 2'd3, 5'd31, 6'd1,  0));
`ifdef MKIO_BCAST_EN
      vecs.push_back(mk("bc_rx",    16'hF843, 0,  3, -1,  3, 1, 0, 0, 0, 2'd3, 5'd2,  6'd3,  1));
      vecs.push_back(mk("bc_tx",    16'hFC22, 0,  0, -1,  0, 0, 0, 0, 0, 2'd3, 5'd2,  6'd3,  1));
      vecs.push_back(mk("bc_mode",  16'hF802, 0,  0, -1,  0, 0, 0, 1, 0, 2'd3, 5'd0,  6'd2,  1));
`else
      vecs.push_back(mk("bc_rx",    16'hF843, 0,  3, -1,  0, 0, 0, 0, 0, 2'd3, 5'd31, 6'd1,  0));
      vecs.push_back(mk("bc_tx",    16'hFC22, 0,  0, -1,  0, 0, 0, 0, 0, 2'd3, 5'd31, 6'd1,  0));
      vecs.push_back(mk("bc_mode",  16'hF802, 0,  0, -1,  0, 0, 0, 0, 0, 2'd3, 5'd31, 6'd1,  0));
`endif
      vecs.push_back(mk("rx_after", 16'h0843, 0,  3, -1,  3, 1, 0, 0, 0, 2'd3, 5'd2,  6'd3,  0));

      idle(3);
      check("reset_state", all_outs(), 64'd0);
      reset_n = 1'b1;
      idle(2);

      foreach (vecs[k]) begin
         v = vecs[k];
         b_done = n_done; b_tx = n_tx; b_mode = n_mode; b_err = n_err;
         strobe(v.cmd, 1'b1, v.cmd_par);
         for (int i = 0; i < v.ndata; i++) begin
            logic [15:0] d;
            d = 16'($urandom);
            if (i < v.exp_wr) exp_q.push_back({AW'(i), d});
            strobe(d, 1'b0, (i == v.bad_idx));
         end
         idle(GAP + 8);
         drain(v.name);
         check({v.name, ".done"},    64'(n_done - b_done), 64'(v.exp_done));
         check({v.name, ".tx_req"},  64'(n_tx - b_tx),     64'(v.exp_tx));
         check({v.name, ".mode_req"},64'(n_mode - b_mode), 64'(v.exp_mode));
         check({v.name, ".msg_err"}, 64'(n_err - b_err),   64'(v.exp_err));
         check({v.name, ".err_code"},64'(err_code),        64'(v.exp_code));
         check({v.name, ".subaddr"}, 64'(msg_subaddr),     64'(v.exp_sa));
         check({v.name, ".count"},   64'(msg_count),       64'(v.exp_cnt));
         check({v.name, ".bcast"},   64'(msg_bcast),       64'(v.exp_bc));
         check({v.name, ".busy"},    64'(busy),            64'd0);
      end

      // Words arriving exactly GAP_TIMEOUT idle cycles apart are still accepted.
      b_done = n_done; b_err = n_err;
      strobe(16'h0843, 1'b1, 1'b0);
      data(0, 1'b1);
      idle(GAP);
      data(1, 1'b1);
      idle(GAP);
      data(2, 1'b1);
      @(negedge clk);
      check("edge.wren_last", 64'(bus.mem_wren), 64'd1);
      check("edge.addr_last", 64'(bus.mem_wraddress), 64'd2);
      check("edge.done_early", 64'(msg_done), 64'd0);
      check("edge.busy_last", 64'(busy), 64'd1);
      @(negedge clk);
      check("edge.done_t2", 64'(msg_done), 64'd1);
      check("edge.busy_t2", 64'(busy), 64'd0);
      @(posedge clk); #1;
      idle(4);
      drain("edge");
      check("edge.err", 64'(n_err - b_err), 64'd0);
      check("edge.done_cnt", 64'(n_done - b_done), 64'd1);

      // A command word mid-message aborts with SYNC and is taken as the next command.
      b_tx = n_tx;
      strobe(16'h0843, 1'b1, 1'b0);
      data(0, 1'b1);
      strobe(16'h0C22, 1'b1, 1'b0);
      @(negedge clk);
      check("sync.msg_err", 64'(msg_err), 64'd1);
      check("sync.tx_req", 64'(tx_req), 64'd1);
      check("sync.err_code", 64'(err_code), 64'd2);
      check("sync.busy", 64'(busy), 64'd0);
      @(posedge clk); #1;
      idle(4);
      drain("sync");
      check("sync.subaddr", 64'(msg_subaddr), 64'd1);
      check("sync.tx_cnt", 64'(n_tx - b_tx), 64'd1);

      // An own address of 31 must not turn a broadcast transmit into tx_req.
      rt_addr = 5'd31;
      b_tx = n_tx; b_mode = n_mode;
      strobe(16'hFC22, 1'b1, 1'b0);
      idle(4);
      check("rt31.tx", 64'(n_tx - b_tx), 64'd0);
      check("rt31.mode", 64'(n_mode - b_mode), 64'd0);
      check("rt31.subaddr", 64'(msg_subaddr), 64'd1);
      rt_addr = 5'd1;

      // Reset mid-message: everything clears, the concurrent word is not written, no msg_err.
      b_err = n_err; b_done = n_done;
      strobe(16'h0843, 1'b1, 1'b0);
      data(0, 1'b1);
      reset_n = 1'b0;
      data(1, 1'b0);
      @(negedge clk);
      check("rst.outputs", all_outs(), 64'd0);
      reset_n = 1'b1;
      @(posedge clk); #1;
      idle(GAP + 8);
      drain("rst");
      check("rst.err", 64'(n_err - b_err), 64'd0);
      check("rst.done", 64'(n_done - b_done), 64'd0);
      check("rst.busy", 64'(busy), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
